gf180mcu_fd_io__pwrseq: RTL and testbench

Pad-ring power-sequencing controller. It consumes the supply-good indications for the DVDD/DVSS and VDD/VSS rails that the corner and supply cells distribute around the ring. From them it produces ordered, glitch-free control for the IO cells: power-on reset release, isolation, input enable and output enable. It sits in the always-on core region beside the ring. Core logic drives it through a single request/ready pair.

---
 rtl/gf180mcu_fd_io__pwrseq.sv | 133 +++++++++++++
 tb/tb_gf180mcu_fd_io__pwrseq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_io__pwrseq.sv
// Pad-ring power sequencer: debounced POR release, then isolation/IE/OE ordering on request.
// Define GF180MCU_FD_IO_PWRSEQ_STATUS_EN to expose STATE and a saturating BROWNOUT_CNT.
module gf180mcu_fd_io__pwrseq #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8,
    parameter int DEB_CYCLES  = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       VDD_OK,
    input  logic       DVDD_OK,
    input  logic       PWR_REQ,
    output logic       POR_N,
    output logic       ISO,
    output logic       IE,
    output logic       OE,
`ifdef GF180MCU_FD_IO_PWRSEQ_STATUS_EN
    output logic       READY,
    output logic [3:0] STATE,
    output logic [7:0] BROWNOUT_CNT
`else
    output logic       READY
`endif
);

    localparam logic [3:0] S_OFF   = 4'd0;
    localparam logic [3:0] S_DEB   = 4'd1;
    localparam logic [3:0] S_POR   = 4'd2;
    localparam logic [3:0] S_IDLE  = 4'd3;
    localparam logic [3:0] S_UNISO = 4'd4;
    localparam logic [3:0] S_IE    = 4'd5;
    localparam logic [3:0] S_ON    = 4'd6;
    localparam logic [3:0] S_OEOFF = 4'd7;
    localparam logic [3:0] S_IEOFF = 4'd8;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] STEP_LAST = DEB_W'(STEP_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_vdd_sync;
    logic [SYNC_STAGES-1:0] r_dvdd_sync;
    logic [3:0]             r_state;
    logic [3:0]             w_state_next;
    logic [DEB_W-1:0]       r_cnt;
    logic [4:0]             r_outs;
    logic                   w_good;
    logic                   w_supply_loss;
    logic                   w_dwell_done;

    // Output bits {POR_N, ISO, IE, OE, READY}; unused codes decode to the safe S_OFF values.
    function automatic logic [4:0] f_outs(input logic [3:0] s);
        case (s)
            S_POR, S_IDLE:   f_outs = 5'b11000;
            S_UNISO:         f_outs = 5'b10000;
            S_IE, S_OEOFF:   f_outs = 5'b10100;
            S_ON:            f_outs = 5'b10111;
            S_IEOFF:         f_outs = 5'b10000;
            default:         f_outs = 5'b01000;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vdd_sync  <= '0;
            r_dvdd_sync <= '0;
        end else begin
            r_vdd_sync  <= {r_vdd_sync[SYNC_STAGES-2:0], VDD_OK};
            r_dvdd_sync <= {r_dvdd_sync[SYNC_STAGES-2:0], DVDD_OK};
        end
    end

    assign w_good        = r_vdd_sync[SYNC_STAGES-1] & r_dvdd_sync[SYNC_STAGES-1];
    assign w_supply_loss = (r_state != S_OFF) && !w_good;
    assign w_dwell_done  = (r_cnt == STEP_LAST);

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (w_supply_loss) begin
            w_state_next = S_OFF;
        end else begin
            case (r_state)
                S_OFF:   if (w_good) w_state_next = S_DEB;
                S_DEB:   if (r_cnt == DEB_LAST) w_state_next = S_POR;
                S_POR:   if (w_dwell_done) w_state_next = S_IDLE;
                S_IDLE:  if (PWR_REQ) w_state_next = S_UNISO;
                S_UNISO: if (!PWR_REQ) w_state_next = S_IEOFF;
                         else if (w_dwell_done) w_state_next = S_IE;
                S_IE:    if (!PWR_REQ) w_state_next = S_IEOFF;
                         else if (w_dwell_done) w_state_next = S_ON;
                S_ON:    if (!PWR_REQ) w_state_next = S_OEOFF;
                S_OEOFF: if (w_dwell_done) w_state_next = S_IEOFF;
                S_IEOFF: if (w_dwell_done) w_state_next = S_IDLE;
                default: w_state_next = S_OFF;
            endcase
        end
    end

    // Outputs are flopped from the next-state decode: identical timing to decoding r_state,
    // but each pad control comes straight off a flop and cannot glitch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_OFF;
            r_cnt   <= '0;
            r_outs  <= f_outs(S_OFF);
        end else begin
            r_state <= w_state_next;
            r_outs  <= f_outs(w_state_next);
            if (w_state_next != r_state) r_cnt <= '0;
            else                         r_cnt <= r_cnt + DEB_W'(1);
        end
    end

    assign POR_N = r_outs[4];
    assign ISO   = r_outs[3];
    assign IE    = r_outs[2];
    assign OE    = r_outs[1];
    assign READY = r_outs[0];

`ifdef GF180MCU_FD_IO_PWRSEQ_STATUS_EN
    logic [7:0] r_brownout;

    always_ff @(posedge CLK) begin
        if (RST)                                     r_brownout <= '0;
        else if (w_supply_loss && r_brownout != 8'hFF) r_brownout <= r_brownout + 8'd1;
    end

    assign STATE        = r_state;
    assign BROWNOUT_CNT = r_brownout;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_io__pwrseq.sv
// Bench for gf180mcu_fd_io__pwrseq: directed sequencing scenarios then randomized supply/request
// traffic, every cycle compared with a countdown-based phase model.
module tb_gf180mcu_fd_io__pwrseq;

    localparam int SYNC_STAGES = 2;
    localparam int DEB_W       = 8;
    localparam int DEB_CYCLES  = 16;
    localparam int STEP_CYCLES = 8;

    logic CLK, RST, VDD_OK, DVDD_OK, PWR_REQ;
    logic POR_N, ISO, IE, OE, READY;
`ifdef GF180MCU_FD_IO_PWRSEQ_STATUS_EN
    logic [3:0] STATE;
    logic [7:0] BROWNOUT_CNT;
`endif

    gf180mcu_fd_io__pwrseq #(
        .SYNC_STAGES(SYNC_STAGES), .DEB_W(DEB_W),
        .DEB_CYCLES(DEB_CYCLES), .STEP_CYCLES(STEP_CYCLES)
    ) dut (
        .CLK(CLK), .RST(RST), .VDD_OK(VDD_OK), .DVDD_OK(DVDD_OK), .PWR_REQ(PWR_REQ),
        .POR_N(POR_N), .ISO(ISO), .IE(IE), .OE(OE),
`ifdef GF180MCU_FD_IO_PWRSEQ_STATUS_EN
        .READY(READY), .STATE(STATE), .BROWNOUT_CNT(BROWNOUT_CNT)
`else
        .READY(READY)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: named phases with a countdown of edges left before the next step.
    typedef enum int {P_OFF, P_DEB, P_POR, P_IDLE, P_UNISO, P_IE, P_ON, P_OEOFF, P_IEOFF} phase_t;
    phase_t m_ph = P_OFF;
    int     m_rem = 0;
    int     m_brown = 0;
    bit     m_vq[$];
    bit     m_dq[$];

    function automatic logic [4:0] exp_outs(input phase_t p);
        case (p)
            P_POR, P_IDLE:  return 5'b11000;
            P_UNISO:        return 5'b10000;
            P_IE:           return 5'b10100;
            P_ON:           return 5'b10111;
            P_OEOFF:        return 5'b10100;
            P_IEOFF:        return 5'b10000;
            default:        return 5'b01000;
        endcase
    endfunction

    task automatic model_step();
        bit good;
        if (RST) begin
            m_vq.delete();
            m_dq.delete();
            for (int i = 0; i < SYNC_STAGES; i++) begin
                m_vq.push_back(1'b0);
                m_dq.push_back(1'b0);
            end
            m_ph = P_OFF; m_rem = 0; m_brown = 0;
            return;
        end
        good = m_vq[0] && m_dq[0];
        if (m_ph != P_OFF && !good) begin
            m_ph = P_OFF;
            if (m_brown < 255) m_brown++;
        end else begin
            case (m_ph)
                P_OFF:  if (good) begin m_ph = P_DEB; m_rem = DEB_CYCLES; end
                P_DEB:  begin m_rem--; if (m_rem == 0) begin m_ph = P_POR; m_rem = STEP_CYCLES; end end
                P_POR:  begin m_rem--; if (m_rem == 0) m_ph = P_IDLE; end
                P_IDLE: if (PWR_REQ) begin m_ph = P_UNISO; m_rem = STEP_CYCLES; end
                P_UNISO, P_IE: begin
                    if (!PWR_REQ) begin
                        m_ph = P_IEOFF; m_rem = STEP_CYCLES;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_ph = (m_ph == P_UNISO) ? P_IE : P_ON;
                            m_rem = STEP_CYCLES;
                        end
                    end
                end
                P_ON:    if (!PWR_REQ) begin m_ph = P_OEOFF; m_rem = STEP_CYCLES; end
                P_OEOFF: begin m_rem--; if (m_rem == 0) begin m_ph = P_IEOFF; m_rem = STEP_CYCLES; end end
                P_IEOFF: begin m_rem--; if (m_rem == 0) m_ph = P_IDLE; end
                default: m_ph = P_OFF;
            endcase
        end
        m_vq.push_back(VDD_OK);  void'(m_vq.pop_front());
        m_dq.push_back(DVDD_OK); void'(m_dq.pop_front());
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled, then compare after the edge.
    task automatic tick();
        logic [4:0] e;
        @(posedge CLK);
        model_step();
        #1;
        e = exp_outs(m_ph);
        check("POR_N", {7'd0, POR_N}, {7'd0, e[4]});
        check("ISO",   {7'd0, ISO},   {7'd0, e[3]});
        check("IE",    {7'd0, IE},    {7'd0, e[2]});
        check("OE",    {7'd0, OE},    {7'd0, e[1]});
        check("READY", {7'd0, READY}, {7'd0, e[0]});
`ifdef GF180MCU_FD_IO_PWRSEQ_STATUS_EN
        check("STATE", {4'd0, STATE}, 8'(int'(m_ph)));
        check("BROWNOUT_CNT", BROWNOUT_CNT, 8'(m_brown));
`endif
    endtask

    function automatic logic out_sel(input int which);
        case (which)
            0:       return POR_N;
            1:       return ISO;
            2:       return IE;
            3:       return OE;
            default: return READY;
        endcase
    endfunction

    // Edges until the selected output reaches val; returns the budget if it never does.
    task automatic ticks_until(input int which, input logic val, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (out_sel(which) !== val && n < 60);
    endtask

    int n;
    int bad_left;
    int bad_mask;

    initial begin
        RST = 1'b1; VDD_OK = 1'b0; DVDD_OK = 1'b0; PWR_REQ = 1'b0;
        repeat (3) tick();

        // Power-up from a reset edge (edge 0) with everything asserted.
        tick();
        RST = 1'b0; VDD_OK = 1'b1; DVDD_OK = 1'b1; PWR_REQ = 1'b1;
        ticks_until(0, 1'b1, n); check("pwrup_por_edge", 8'(n), 8'd19);
        ticks_until(1, 1'b0, n); check("pwrup_iso_edge", 8'(19 + n), 8'd28);
        ticks_until(2, 1'b1, n); check("pwrup_ie_edge",  8'(28 + n), 8'd36);
        ticks_until(3, 1'b1, n); check("pwrup_oe_edge",  8'(36 + n), 8'd44);
        check("pwrup_ready", {7'd0, READY}, 8'd1);

        // Orderly power-down from S_ON.
        repeat (2) tick();
        PWR_REQ = 1'b0;
        ticks_until(3, 1'b0, n); check("pdn_oe_edge", 8'(n), 8'd1);
        check("pdn_ready_low", {7'd0, READY}, 8'd0);
        ticks_until(2, 1'b0, n); check("pdn_ie_edge", 8'(n), 8'd8);
        ticks_until(1, 1'b1, n); check("pdn_iso_edge", 8'(n), 8'd8);

        // Request dropped in S_IE, reasserted in S_IEOFF: power-down completes, then restarts.
        tick();
        PWR_REQ = 1'b1;
        ticks_until(2, 1'b1, n); check("toggle_ie_edge", 8'(n), 8'd9);
        repeat (2) tick();
        PWR_REQ = 1'b0;
        ticks_until(2, 1'b0, n); check("toggle_ieoff_edge", 8'(n), 8'd1);
        repeat (3) tick();
        PWR_REQ = 1'b1;
        ticks_until(1, 1'b1, n); check("toggle_idle_edge", 8'(n), 8'd5);
        ticks_until(1, 1'b0, n); check("toggle_uniso_edge", 8'(n), 8'd1);
        ticks_until(4, 1'b1, n); check("toggle_ready_edge", 8'(n), 8'd16);

        // One-cycle reset while fully on, then identical resequencing.
        tick();
        RST = 1'b1;
        tick();
        check("rst_por_n", {7'd0, POR_N}, 8'd0);
        check("rst_iso",   {7'd0, ISO},   8'd1);
        check("rst_ready", {7'd0, READY}, 8'd0);
        RST = 1'b0;
        ticks_until(0, 1'b1, n); check("reseq_por_edge", 8'(n), 8'd19);
        ticks_until(4, 1'b1, n); check("reseq_ready_edge", 8'(19 + n), 8'd44);

        // Core rail lost while on.
        tick();
        VDD_OK = 1'b0;
        ticks_until(0, 1'b0, n); check("vdd_loss_edge", 8'(n), 8'd3);
        check("vdd_loss_iso", {7'd0, ISO}, 8'd1);
        check("vdd_loss_oe",  {7'd0, OE},  8'd0);
`ifdef GF180MCU_FD_IO_PWRSEQ_STATUS_EN
        check("brownout_one", BROWNOUT_CNT, 8'd1);
`endif

        // Short IO-rail glitch during debounce restarts the debounce window.
        repeat (2) tick();
        VDD_OK = 1'b1;
        repeat (8) tick();
        DVDD_OK = 1'b0;
        repeat (3) tick();
        DVDD_OK = 1'b1;
        ticks_until(0, 1'b1, n); check("glitch_por_edge", 8'(n), 8'd19);

        // Randomized supply dropouts, request toggles and occasional resets.
        bad_left = 0;
        bad_mask = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            RST = ($urandom_range(0, 599) == 0);
            if (bad_left == 0 && $urandom_range(0, 249) == 0) begin
                bad_left = $urandom_range(1, 24);
                bad_mask = $urandom_range(1, 3);
            end
            if (bad_left > 0) begin
                VDD_OK  = !bad_mask[0];
                DVDD_OK = !bad_mask[1];
                bad_left--;
            end else begin
                VDD_OK  = 1'b1;
                DVDD_OK = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) PWR_REQ = !PWR_REQ;
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
